// File: rtl/game_pkg.sv
// Shared types and helpers for the game score controller: state encoding,
// 7-segment decode and BCD arithmetic.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } game_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segments g..a, active-low; non-decimal codes stay dark.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg_v;
        case (digit)
            4'd0:    seg_v = 7'h40;
            4'd1:    seg_v = 7'h79;
            4'd2:    seg_v = 7'h24;
            4'd3:    seg_v = 7'h30;
            4'd4:    seg_v = 7'h19;
            4'd5:    seg_v = 7'h12;
            4'd6:    seg_v = 7'h02;
            4'd7:    seg_v = 7'h78;
            4'd8:    seg_v = 7'h00;
            4'd9:    seg_v = 7'h10;
            default: seg_v = SEG_BLANK;
        endcase
        return seg_v;
    endfunction

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r_v;
        if (v == 8'h99) begin
            r_v = 8'h99;
        end else if (v[3:0] == 4'd9) begin
            r_v = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r_v = {v[7:4], v[3:0] + 4'd1};
        end
        return r_v;
    endfunction

    // Borrow from tens on 0 ones; 00 stays 00 so a stray tick cannot wrap.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r_v;
        if (v == 8'h00) begin
            r_v = 8'h00;
        end else if (v[3:0] == 4'd0) begin
            r_v = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r_v = {v[7:4], v[3:0] - 4'd1};
        end
        return r_v;
    endfunction

    function automatic logic [7:0] int_to_bcd(input int unsigned n);
        logic [3:0] tens_v;
        logic [3:0] ones_v;
        tens_v = 4'(n / 32'd10);
        ones_v = 4'(n % 32'd10);
        return {tens_v, ones_v};
    endfunction

endpackage

// File: rtl/game_score_ctrl_sync_edge.sv
// Two-flop synchronizer for an asynchronous level followed by a registered
// one-clock rising-edge pulse (pulse appears 3 clks after the input rises).
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    // Synchronize, keep the previous sample, and register the rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= i_async;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/game_score_ctrl.sv
// Round controller: runs a timed round, counts hit pulses into a BCD score,
// counts down the time and scans both onto a 4-digit common-anode display.
module game_score_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned GAME_SECS = 30,
    parameter int unsigned SCAN_DIV  = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       add_point,
    output logic       working_sig,
    output logic       game_over,
    output logic [7:0] score_bcd,
    output logic [7:0] time_bcd,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [7:0]        GAME_BCD  = int_to_bcd(GAME_SECS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 32'd1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(32'd1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 32'd1);
    localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(32'd1);

    logic w_start_pulse;
    logic w_hit_pulse;

    game_state_e       r_state;
    logic              r_working;
    logic              r_over;
    logic [7:0]        r_score;
    logic [7:0]        r_time;
    logic [TICK_W-1:0] r_tick_cnt;

    logic [SCAN_W-1:0] r_scan_cnt;
    logic [1:0]        r_dig_idx;
    logic [6:0]        r_seg;
    logic [3:0]        r_an;
    logic [6:0]        w_seg;
    logic [3:0]        w_an;

    sync_edge u_start_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (start),
        .o_pulse (w_start_pulse)
    );

    sync_edge u_hit_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (add_point),
        .o_pulse (w_hit_pulse)
    );

    // Round FSM: entry actions, per-second countdown and hit scoring
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_working  <= 1'b0;
            r_over     <= 1'b0;
            r_score    <= 8'h00;
            r_time     <= GAME_BCD;
            r_tick_cnt <= {TICK_W{1'b0}};
        end else begin
            case (r_state)
                IDLE, OVER: begin
                    if (w_start_pulse) begin
                        r_state    <= RUN;
                        r_working  <= 1'b1;
                        r_over     <= 1'b0;
                        r_score    <= 8'h00;
                        r_time     <= GAME_BCD;
                        r_tick_cnt <= {TICK_W{1'b0}};
                    end
                end
                RUN: begin
                    // A hit on the final tick still counts before the round closes.
                    if (w_hit_pulse) begin
                        r_score <= bcd_inc_sat(r_score);
                    end
                    if (r_tick_cnt == TICK_LAST) begin
                        r_tick_cnt <= {TICK_W{1'b0}};
                        r_time     <= bcd_dec(r_time);
                        if (r_time == 8'h01) begin
                            r_state   <= OVER;
                            r_working <= 1'b0;
                            r_over    <= 1'b1;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + TICK_ONE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_working <= 1'b0;
                    r_over    <= 1'b0;
                end
            endcase
        end
    end

    // Scan divider advancing the displayed digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= {SCAN_W{1'b0}};
            r_dig_idx  <= 2'd0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= {SCAN_W{1'b0}};
            r_dig_idx  <= r_dig_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_ONE;
        end
    end

    // Digit select and decode with leading-zero blanking on both tens digits
    always_comb begin
        w_an  = 4'hF;
        w_seg = SEG_BLANK;
        case (r_dig_idx)
            2'd0: begin
                w_an  = 4'b1110;
                w_seg = bcd_to_seg(r_time[3:0]);
            end
            2'd1: begin
                w_an  = 4'b1101;
                w_seg = (r_time[7:4] == 4'd0) ? SEG_BLANK : bcd_to_seg(r_time[7:4]);
            end
            2'd2: begin
                w_an  = 4'b1011;
                w_seg = bcd_to_seg(r_score[3:0]);
            end
            2'd3: begin
                w_an  = 4'b0111;
                w_seg = (r_score[7:4] == 4'd0) ? SEG_BLANK : bcd_to_seg(r_score[7:4]);
            end
            default: begin
                w_an  = 4'hF;
                w_seg = SEG_BLANK;
            end
        endcase
    end

    // Registered display drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= 4'hF;
        end else begin
            r_seg <= w_seg;
            r_an  <= w_an;
        end
    end

    assign working_sig = r_working;
    assign game_over   = r_over;
    assign score_bcd   = r_score;
    assign time_bcd    = r_time;
    assign seg         = r_seg;
    assign an          = r_an;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Self-checking bench for game_score_ctrl: per-cycle vector table for a full
// round, hand sequences for corner cases, and a score scoreboard.
module tb_game_score_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, hit;
    logic       ws, go;
    logic [7:0] score, tval;
    logic [6:0] seg;
    logic [3:0] an;

    logic       start1, hit1;
    logic       ws1, go1;
    logic [7:0] score1, time1;
    logic [6:0] seg1;
    logic [3:0] an1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sb_q[$];
    logic [7:0] sb_prev;
    logic [7:0] m_score;

    typedef struct {
        logic       st;
        logic       ht;
        logic       push;
        logic       ws;
        logic       go;
        logic [7:0] sc;
        logic [7:0] tm;
    } vec_t;

    vec_t vecs[21];

    always #5 clk = ~clk;

    game_score_ctrl #(.TICK_DIV(4), .GAME_SECS(3), .SCAN_DIV(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .add_point(hit),
        .working_sig(ws), .game_over(go), .score_bcd(score), .time_bcd(tval),
        .seg(seg), .an(an)
    );

    game_score_ctrl #(.TICK_DIV(16), .GAME_SECS(99), .SCAN_DIV(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .add_point(hit1),
        .working_sig(ws1), .game_over(go1), .score_bcd(score1), .time_bcd(time1),
        .seg(seg1), .an(an1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_inc(input logic [7:0] v);
        int d;
        d = int'(v[7:4]) * 10 + int'(v[3:0]);
        if (d < 99) d++;
        return {4'(d / 10), 4'(d % 10)};
    endfunction

    // Score scoreboard: every change of u0 score must match the next queued value
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_prev = score;
        end else if (score !== sb_prev) begin
            if (sb_q.size() == 0) check("score_unexpected", {24'd0, score}, {24'd0, sb_prev});
            else check("score_sb", {24'd0, score}, {24'd0, sb_q.pop_front()});
            sb_prev = score;
        end
    end

    task automatic hits1(input int n);
        for (int k = 0; k < n; k++) begin
            hit1 = 1'b1;
            @(negedge clk);
            hit1 = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_an[5];
        logic [6:0] exp_seg[5];
        logic [3:0] prev_an;
        logic       got;

        exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
        exp_seg = '{7'h30, 7'h7F, 7'h40, 7'h7F, 7'h30};

        //            st    ht    push  ws    go    score  time
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h03};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h03};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h02};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h02};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 8'h02};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h02, 8'h02};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 8'h01};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 8'h01};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 8'h01};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 8'h01};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00};

        rst_n = 1'b0; start = 1'b0; hit = 1'b0; start1 = 1'b0; hit1 = 1'b0;
        m_score = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_ws", ws, 1'b0);
        check("rst_go", go, 1'b0);
        check("rst_score", score, 8'h00);
        check("rst_time", tval, 8'h03);
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 4'hF);
        check("rst_time1", time1, 8'h99);
        check("rst_an1", an1, 4'hF);
        check("rst_seg1", seg1, 7'h7F);

        // IDLE display scan: digit 0 first, tens digits blanked
        rst_n = 1'b1;
        prev_an = an;
        for (int k = 0; k < 5; k++) begin
            got = 1'b0;
            for (int c = 0; c < 12 && !got; c++) begin
                @(negedge clk);
                if (an !== prev_an) got = 1'b1;
            end
            check($sformatf("disp%0d_change", k), got, 1'b1);
            check($sformatf("disp%0d_an", k), an, exp_an[k]);
            check($sformatf("disp%0d_seg", k), seg, exp_seg[k]);
            prev_an = an;
        end
        check("idle_ws", ws, 1'b0);
        check("idle_score", score, 8'h00);

        // Full round: start, 5 hits, last hit on the final tick, hit in OVER
        for (int i = 0; i < 21; i++) begin
            start = vecs[i].st;
            hit   = vecs[i].ht;
            if (vecs[i].push) begin
                m_score = model_inc(m_score);
                sb_q.push_back(m_score);
            end
            @(negedge clk);
            check($sformatf("row%0d_ws", i), ws, vecs[i].ws);
            check($sformatf("row%0d_go", i), go, vecs[i].go);
            check($sformatf("row%0d_score", i), score, vecs[i].sc);
            check($sformatf("row%0d_time", i), tval, vecs[i].tm);
        end

        // Restart from OVER
        start = 1'b1;
        sb_q.push_back(8'h00);
        m_score = 8'h00;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("restart_lat_ws", ws, 1'b0);
        @(negedge clk);
        check("restart_ws", ws, 1'b1);
        check("restart_go", go, 1'b0);
        check("restart_score", score, 8'h00);
        check("restart_time", tval, 8'h03);

        // Held hit counts once
        hit = 1'b1;
        m_score = model_inc(m_score);
        sb_q.push_back(m_score);
        repeat (20) @(negedge clk);
        hit = 1'b0;
        check("hold_once", score, 8'h01);
        check("hold_over", go, 1'b1);

        // New round, two hits, start in RUN ignored, then async reset
        start = 1'b1;
        sb_q.push_back(8'h00);
        m_score = 8'h00;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("run2_ws", ws, 1'b1);
        hit = 1'b1; m_score = model_inc(m_score); sb_q.push_back(m_score);
        @(negedge clk);
        hit = 1'b0;
        @(negedge clk);
        hit = 1'b1; m_score = model_inc(m_score); sb_q.push_back(m_score);
        @(negedge clk);
        hit = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("norestart_ws", ws, 1'b1);
        check("norestart_go", go, 1'b0);
        check("norestart_score", score, 8'h02);
        check("norestart_time", tval, 8'h01);
        check("sb_drained", sb_q.size(), 0);

        #2 rst_n = 1'b0;
        #1;
        check("arst_ws", ws, 1'b0);
        check("arst_go", go, 1'b0);
        check("arst_score", score, 8'h00);
        check("arst_time", tval, 8'h03);
        check("arst_seg", seg, 7'h7F);
        check("arst_an", an, 4'hF);
        m_score = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_ws", ws, 1'b0);

        // Second instance: BCD carry 09->10 and saturation at 99
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        check("u1_ws", ws1, 1'b1);
        hits1(9);
        check("u1_score09", score1, 8'h09);
        hits1(1);
        check("u1_score10", score1, 8'h10);
        hits1(89);
        check("u1_score99", score1, 8'h99);
        hits1(1);
        check("u1_sat99", score1, 8'h99);
        check("u1_still_run", ws1, 1'b1);
        check("u1_go", go1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
